// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI register-write controller.
// Frame layout: [15] R/W (1 = write), [14:8] address, [7:0] data, sent MSB first.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int RW_BIT  = 15;

  // Peripheral-side register map; addresses above ADDR_PWM_DUTY are still sent
  // unchanged and left for the peripheral to discard.
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Packs one request into the on-wire frame.
  function automatic logic [FRAME_W-1:0] make_frame(input logic              write,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {write, addr, data};
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request/response bundle of the SPI controller.
// master: the test/config agent issuing register accesses; slave: spi_controller.
interface spi_controller_if;
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req_valid, req_write, req_addr, req_data,
    input  req_ready, busy, done, rd_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    output req_ready, busy, done, rd_data
  );

endinterface

// File: rtl/spi_clk_div.sv
// Phase timer for the SPI controller: phase_tick pulses on the last cycle of
// every CLK_DIV-cycle phase while run is high. start restarts the count and
// the counter is held at zero whenever run is low.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic phase_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end     = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign phase_tick = run && at_end;

  // Next count: wrap at the end of a phase, clear on restart or while stopped.
  always_comb begin
    if (start || !run || at_end) cnt_d = '0;
    else                         cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator for the on-chip register-write link.
// One request per valid/ready handshake is sent as a 16-bit frame
// {write, addr[6:0], data[7:0]}, MSB first, on ncs/sclk/copi.
// Optional build macro SPI_CTRL_READBACK_EN: captures cipo during the data
// phase of read frames into rd_data; without it rd_data is constant 0.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  bus,
  output logic             sclk,
  output logic             ncs,
  output logic             copi,
  input  logic             cipo
);

  localparam int GAP_W = $clog2(CS_GAP);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               sclk_q, sclk_d;
  logic               ncs_q, ncs_d;
  logic               copi_q, copi_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic accept;
  logic div_run;
  logic phase_tick;

  assign accept  = bus.req_valid && ready_q;
  assign div_run = (state_q == SHIFT) || (state_q == HOLD);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept),
    .run        (div_run),
    .phase_tick (phase_tick)
  );

  // Frame sequencer: IDLE -> SHIFT (16 low/high sclk phase pairs) -> HOLD -> GAP.
  always_comb begin
    // NOTE: every _d starts from its _q value so partial assignments below
    // never infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    ncs_d     = ncs_q;
    copi_d    = copi_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          shift_d   = make_frame(bus.req_write, bus.req_addr, bus.req_data);
          bit_cnt_d = 4'd15;
          ncs_d     = 1'b0;
          sclk_d    = 1'b0;
          copi_d    = bus.req_write;
        end
      end
      SHIFT: begin
        if (phase_tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              // Rotate rather than zero-fill; copi only ever looks at the next bit.
              bit_cnt_d = bit_cnt_q - 4'd1;
              shift_d   = {shift_q[FRAME_W-2:0], shift_q[FRAME_W-1]};
              copi_d    = shift_q[FRAME_W-2];
            end
          end
        end
      end
      HOLD: begin
        if (phase_tick) begin
          state_d   = GAP;
          ncs_d     = 1'b1;
          copi_d    = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(CS_GAP - 1)) state_d   = IDLE;
        else                                 gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // Sequencer and pin registers; reset parks the link with ncs high.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk          = sclk_q;
  assign ncs           = ncs_q;
  assign copi          = copi_q;
  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef SPI_CTRL_READBACK_EN
  logic              is_write_q, is_write_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Readback: sample cipo on the 8 data-phase rising edges, publish on done of reads.
  always_comb begin
    is_write_d = is_write_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    if (accept) is_write_d = bus.req_write;
    if ((state_q == SHIFT) && phase_tick && !sclk_q && (bit_cnt_q < 4'd8))
      rx_d = {rx_q[DATA_W-2:0], cipo};
    if ((state_q == HOLD) && phase_tick && !is_write_q)
      rd_data_d = rx_q;
  end

  // Readback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write_q <= 1'b0;
      rx_q       <= '0;
      rd_data_q  <= '0;
    end else begin
      is_write_q <= is_write_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;
`else
  logic unused_cipo;
  assign unused_cipo = cipo;
  assign bus.rd_data = '0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller (CLK_DIV=4, CS_GAP=4) with a behavioural
// mode-0 register peripheral on the SPI pins.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, ncs, copi, cipo;

  spi_controller_if bus ();

  spi_controller #(
    .CLK_DIV (4),
    .CS_GAP  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sclk  (sclk),
    .ncs   (ncs),
    .copi  (copi),
    .cipo  (cipo)
  );

  always #5 clk = ~clk;

`ifdef SPI_CTRL_READBACK_EN
  localparam logic [7:0] EXP_RD = 8'h3C;
`else
  localparam logic [7:0] EXP_RD = 8'h00;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      failures++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  // ---------------- peripheral model ----------------
  logic [15:0] p_shift     = '0;
  int          p_rises     = 0;
  int          p_falls     = 0;
  int          last_rises  = 0;
  logic [15:0] last_frame  = '0;
  logic [7:0]  p_regs [5]  = '{default: 8'h00};
  logic [7:0]  p_tx        = 8'h3C;

  // Shift copi in on sclk rises; commit complete write frames when ncs rises.
  always @(posedge sclk or posedge ncs) begin
    if (ncs) begin
      if (p_rises == 16) begin
        last_frame <= p_shift;
        if (p_shift[15] && (p_shift[14:8] <= 7'd4)) p_regs[p_shift[10:8]] <= p_shift[7:0];
      end
      last_rises <= p_rises;
      p_rises    <= 0;
    end else begin
      p_shift <= {p_shift[14:0], copi};
      p_rises <= p_rises + 1;
    end
  end

  // Count sclk falls; the peripheral presents its read byte over the last 8 bits.
  always @(negedge sclk or posedge ncs) begin
    if (ncs) p_falls <= 0;
    else     p_falls <= p_falls + 1;
  end

  assign cipo = (!ncs && p_falls >= 8 && p_falls < 16) ? p_tx[3'(15 - p_falls)] : 1'b0;

  // ---------------- pin monitors (sampled on falling clk) ----------------
  int   cyc = 0, low_run = 0, last_low = 0, high_run = 0, last_high = 0;
  int   done_cnt = 0, last_rise = 0, prev_rise = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ncs === 1'b0) begin
      low_run <= low_run + 1;
      if (high_run != 0) begin last_high <= high_run; high_run <= 0; end
    end else begin
      high_run <= high_run + 1;
      if (low_run != 0) begin last_low <= low_run; low_run <= 0; end
    end
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.busy === 1'b1 && busy_prev !== 1'b1) begin
      prev_rise <= last_rise;
      last_rise <= cyc;
    end
    busy_prev <= bus.busy;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int t = 0;
    while (bus.req_ready !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) check({name, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic send(input string name, input logic w, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    wait_ready(name);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_data  = d;
    @(negedge clk);
    // Scramble the fields after acceptance; the frame must not change.
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_addr  = ~a;
    bus.req_data  = ~d;
  endtask

  task automatic wait_done(input string name, input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) check({name, "_done_timeout"}, 32'(done_cnt), 32'(d0 + 1));
    @(negedge clk);
  endtask

  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] frame;
    int          reg_idx;
    logic [7:0]  reg_val;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    int d0, r0, t;
    logic [15:0] frame_before;

    vecs[0] = '{w: 1'b1, a: 7'h04, d: 8'hA5, frame: 16'h84A5, reg_idx: 4, reg_val: 8'hA5};
    vecs[1] = '{w: 1'b1, a: 7'h00, d: 8'h12, frame: 16'h8012, reg_idx: 0, reg_val: 8'h12};
    vecs[2] = '{w: 1'b1, a: 7'h02, d: 8'h7E, frame: 16'h827E, reg_idx: 2, reg_val: 8'h7E};
    vecs[3] = '{w: 1'b0, a: 7'h03, d: 8'h55, frame: 16'h0355, reg_idx: 3, reg_val: 8'h00};
    vecs[4] = '{w: 1'b1, a: 7'h7F, d: 8'h3C, frame: 16'hFF3C, reg_idx: 1, reg_val: 8'h00};

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // T1: reset values, then req_ready one cycle after release.
    repeat (5) @(negedge clk);
    check("rst_ncs",   32'(ncs),           32'd1);
    check("rst_sclk",  32'(sclk),          32'd0);
    check("rst_copi",  32'(copi),          32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_rd",    32'(bus.rd_data),   32'd0);
    rst_n = 1'b1;
    #1 check("rel_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_high", 32'(bus.req_ready), 32'd1);

    // T2 plus table: frame bits, sclk rises, ncs low time, done count, register effect.
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      send($sformatf("v%0d", i), vecs[i].w, vecs[i].a, vecs[i].d);
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
      wait_done($sformatf("v%0d", i), d0);
      check($sformatf("v%0d_frame", i), 32'(last_frame), 32'(vecs[i].frame));
      check($sformatf("v%0d_rises", i), 32'(last_rises), 32'd16);
      check($sformatf("v%0d_ncs_low", i), 32'(last_low), 32'd132);
      check($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'(d0 + 1));
      check($sformatf("v%0d_reg", i), 32'(p_regs[vecs[i].reg_idx]), 32'(vecs[i].reg_val));
      check($sformatf("v%0d_sclk_idle", i), 32'(sclk), 32'd0);
    end

    // T3: back-to-back with req_valid held; accept spacing 1+132+4.
    @(negedge clk);
    wait_ready("b2b");
    d0 = done_cnt;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 7'h00;
    bus.req_data  = 8'hFF;
    @(negedge clk);
    bus.req_addr  = 7'h01;
    bus.req_data  = 8'h0F;
    @(negedge clk);
    r0 = last_rise;
    t  = 0;
    while (last_rise == r0 && t < 400) begin @(negedge clk); t++; end
    bus.req_valid = 1'b0;
    check("b2b_spacing", 32'(last_rise - prev_rise), 32'd137);
    check_ge("b2b_ncs_gap", last_high, 4);
    wait_done("b2b2", d0 + 1);
    check("b2b_reg0", 32'(p_regs[0]), 32'hFF);
    check("b2b_reg1", 32'(p_regs[1]), 32'h0F);
    check("b2b_frame2", 32'(last_frame), 32'h810F);
    check("b2b_done_cnt", 32'(done_cnt), 32'(d0 + 2));

    // T4: request while busy is ignored, nothing queued.
    d0 = done_cnt;
    send("busy", 1'b1, 7'h04, 8'h5A);
    repeat (40) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 7'h02;
    bus.req_data  = 8'h99;
    repeat (3) @(negedge clk);
    check("busy_ready_low", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    wait_done("busy", d0);
    repeat (20) @(negedge clk);
    check("busy_frame", 32'(last_frame), 32'h845A);
    check("busy_reg4", 32'(p_regs[4]), 32'h5A);
    check("busy_reg2", 32'(p_regs[2]), 32'h7E);
    check("busy_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    check("busy_idle", 32'(bus.busy), 32'd0);

    // T5: reset after 7 sclk rises abandons the frame.
    frame_before = last_frame;
    send("mid_rst", 1'b1, 7'h00, 8'h33);
    t = 0;
    while (p_rises != 7 && t < 200) begin @(negedge clk); t++; end
    rst_n = 1'b0;
    #1;
    check("mrst_ncs",   32'(ncs),        32'd1);
    check("mrst_sclk",  32'(sclk),       32'd0);
    check("mrst_copi",  32'(copi),       32'd0);
    check("mrst_busy",  32'(bus.busy),   32'd0);
    check("mrst_rises", 32'(last_rises), 32'd7);
    check("mrst_rd",    32'(bus.rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_reg0",  32'(p_regs[0]),  32'hFF);
    check("mrst_frame", 32'(last_frame), 32'(frame_before));
    d0 = done_cnt;
    send("post_rst", 1'b1, 7'h00, 8'h44);
    wait_done("post_rst", d0);
    check("post_rst_frame", 32'(last_frame), 32'h8044);
    check("post_rst_reg0",  32'(p_regs[0]),  32'h44);

    // T6: read captures cipo (readback build only); a later write keeps rd_data.
    d0 = done_cnt;
    send("rd", 1'b0, 7'h03, 8'h00);
    wait_done("rd", d0);
    check("rd_frame", 32'(last_frame), 32'h0300);
    check("rd_data",  32'(bus.rd_data), 32'(EXP_RD));
    d0 = done_cnt;
    send("wr_after_rd", 1'b1, 7'h04, 8'h11);
    wait_done("wr_after_rd", d0);
    check("rd_kept", 32'(bus.rd_data), 32'(EXP_RD));
    check("wr_after_rd_reg4", 32'(p_regs[4]), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
